arbitro_contador_rr: RTL

- Round-robin scheduler that shares one modulo-(L+1) counter datapath among N_REQ requesters.
- Each requester asks for a count run with its own limit L. The block grants one requester at a time and runs the shared counter from 0 to L on enabled ticks.
- It then pulses that requester's completion flag and re-arbitrates.
- Sits between requesting control blocks and the shared counter; it sequences and owns the counter register.

---
 rtl/arbitro_contador_rr.sv | 135 +++++++++++++
 1 files changed

// File: rtl/arbitro_contador_rr.sv
// Round-robin scheduler that lends one shared modulo-(L+1) counter to N_REQ requesters,
// running 0..L on enabled ticks for the granted requester and pulsing its completion flag.
module arbitro_contador_rr #(
   parameter  int N_REQ = 4,
   parameter  int W     = 4,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [N_REQ*W-1:0] i_limite,
   input  logic               i_enable,
   output logic [N_REQ-1:0]   o_gnt,
   output logic [IDW-1:0]     o_id,
   output logic               o_ocupado,
   output logic [W-1:0]       o_cuenta,
   output logic [N_REQ-1:0]   o_fin
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CUENTA = 2'd1,
      FIN    = 2'd2
   } estado_t;

   estado_t          estado, estado_nxt;
   logic [N_REQ-1:0] gnt, gnt_nxt;
   logic [N_REQ-1:0] fin, fin_nxt;
   logic [IDW-1:0]   id, id_nxt;
   logic [IDW-1:0]   ptr, ptr_nxt;
   logic [W-1:0]     cuenta, cuenta_nxt;
   logic [W-1:0]     lim, lim_nxt;
   logic             ocupado, ocupado_nxt;

   logic             hay_req;
   logic [IDW-1:0]   ganador;

   // Search starts just after the last served requester so everyone gets a turn.
   always_comb begin
      hay_req = 1'b0;
      ganador = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!hay_req && i_req[(int'(ptr) + i) % N_REQ]) begin
            hay_req = 1'b1;
            ganador = IDW'((int'(ptr) + i) % N_REQ);
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      estado_nxt  = estado;
      gnt_nxt     = gnt;
      fin_nxt     = '0;
      id_nxt      = id;
      ptr_nxt     = ptr;
      cuenta_nxt  = cuenta;
      lim_nxt     = lim;
      ocupado_nxt = ocupado;

      unique case (estado)
         IDLE: begin
            if (hay_req) begin
               estado_nxt       = CUENTA;
               gnt_nxt          = '0;
               gnt_nxt[ganador] = 1'b1;
               id_nxt           = ganador;
               cuenta_nxt       = '0;
               lim_nxt          = i_limite[int'(ganador)*W +: W];
               ocupado_nxt      = 1'b1;
            end
         end

         CUENTA: begin
            // Abort outranks the final tick: a dropped request never sees o_fin.
            if (!i_req[id]) begin
               estado_nxt  = IDLE;
               gnt_nxt     = '0;
               ocupado_nxt = 1'b0;
               ptr_nxt     = id;
            end else if (i_enable && (cuenta == lim)) begin
               estado_nxt  = FIN;
               gnt_nxt     = '0;
               fin_nxt[id] = 1'b1;
            end else if (i_enable) begin
               cuenta_nxt = cuenta + W'(1);
            end
         end

         FIN: begin
            estado_nxt  = IDLE;
            ocupado_nxt = 1'b0;
            ptr_nxt     = id;
         end

         default: begin
            estado_nxt  = IDLE;
            gnt_nxt     = '0;
            ocupado_nxt = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         estado  <= IDLE;
         gnt     <= '0;
         fin     <= '0;
         id      <= '0;
         ptr     <= IDW'(N_REQ - 1);
         cuenta  <= '0;
         lim     <= '0;
         ocupado <= 1'b0;
      end else begin
         estado  <= estado_nxt;
         gnt     <= gnt_nxt;
         fin     <= fin_nxt;
         id      <= id_nxt;
         ptr     <= ptr_nxt;
         cuenta  <= cuenta_nxt;
         lim     <= lim_nxt;
         ocupado <= ocupado_nxt;
      end
   end

   assign o_gnt     = gnt;
   assign o_fin     = fin;
   assign o_id      = id;
   assign o_ocupado = ocupado;
   assign o_cuenta  = cuenta;

endmodule
